// File: rtl/afc_cal_sequencer.sv
// AFC measurement/sequencing controller: settle, count divided-VCO edges, decide FAST/SLOW/FREEZE.
// Optional dead-VCO detection is enabled by defining AFC_SEQ_DEADVCO_EN.
module afc_cal_sequencer #(
    parameter int CNT_W         = 10,
    parameter int WIN_CYCLES    = 256,
    parameter int SETTLE_CYCLES = 32,
    parameter int MAX_ITER      = 7
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [CNT_W-1:0] target_cnt_i,
    input  logic [3:0]       tol_i,
    input  logic             vco_div_i,
    output logic [2:0]       comp_out_o,
    output logic             comp_valid_o,
    output logic             busy_o,
    output logic             cal_done_o,
    output logic             cal_fail_o,
    output logic [CNT_W-1:0] meas_cnt_o,
    output logic [3:0]       iter_cnt_o
);

    localparam int CYC_MAX = (WIN_CYCLES > SETTLE_CYCLES) ? WIN_CYCLES : SETTLE_CYCLES;
    localparam int CYC_W   = $clog2(CYC_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [2:0] DEC_FREEZE = 3'b001;
    localparam logic [2:0] DEC_FAST   = 3'b010;
    localparam logic [2:0] DEC_SLOW   = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE, ST_SETTLE, ST_MEASURE, ST_DECIDE, ST_DONE, ST_FAIL
    } state_e;

    state_e           state_q, state_d;
    logic [2:0]       sync_q;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [CNT_W-1:0] target_q, target_d;
    logic [3:0]       tol_q, tol_d;
    logic [3:0]       iter_q, iter_d;
    logic [CNT_W-1:0] meas_q, meas_d;
    logic [2:0]       comp_q, comp_d;

    logic             rise;
    logic             start_ok;
    logic             commit;
    logic             dead;
    logic             settle_last;
    logic             win_last;
    logic [CNT_W:0]   tol_ext;
    logic [CNT_W:0]   tgt_ext;
    logic [CNT_W:0]   cnt_ext;
    logic [CNT_W:0]   hi_sum;
    logic [CNT_W:0]   hi;
    logic [CNT_W:0]   lo;
    logic [2:0]       decision;
    logic [3:0]       iter_next;

    // sync_q[1] is the synchronized level, sync_q[2] its previous value
    assign rise        = sync_q[1] & ~sync_q[2];
    assign start_ok    = start_i & ((state_q == ST_IDLE) | (state_q == ST_DONE) | (state_q == ST_FAIL));
    assign commit      = (state_q == ST_DECIDE) & ~abort_i;
    assign settle_last = (cyc_q == CYC_W'(SETTLE_CYCLES - 1));
    assign win_last    = (cyc_q == CYC_W'(WIN_CYCLES - 1));
    assign iter_next   = iter_q + 4'd1;

    assign tol_ext  = {{(CNT_W - 3){1'b0}}, tol_q};
    assign tgt_ext  = {1'b0, target_q};
    assign cnt_ext  = {1'b0, edge_cnt_q};
    assign hi_sum   = tgt_ext + tol_ext;
    assign hi       = hi_sum[CNT_W] ? {1'b0, CNT_MAX} : hi_sum;
    assign lo       = (tgt_ext >= tol_ext) ? (tgt_ext - tol_ext) : '0;
    assign decision = (cnt_ext > hi) ? DEC_FAST : ((cnt_ext < lo) ? DEC_SLOW : DEC_FREEZE);

`ifdef AFC_SEQ_DEADVCO_EN
    assign dead = (edge_cnt_q == '0);
`else
    assign dead = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            sync_q     <= '0;
            cyc_q      <= '0;
            edge_cnt_q <= '0;
            target_q   <= '0;
            tol_q      <= '0;
            iter_q     <= '0;
            meas_q     <= '0;
            comp_q     <= '0;
        end else begin
            state_q    <= state_d;
            sync_q     <= {sync_q[1:0], vco_div_i};
            cyc_q      <= cyc_d;
            edge_cnt_q <= edge_cnt_d;
            target_q   <= target_d;
            tol_q      <= tol_d;
            iter_q     <= iter_d;
            meas_q     <= meas_d;
            comp_q     <= comp_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:    if (start_ok) state_d = ST_SETTLE;
                ST_SETTLE:  if (settle_last) state_d = ST_MEASURE;
                ST_MEASURE: if (win_last) state_d = ST_DECIDE;
                ST_DECIDE: begin
                    if (dead)                             state_d = ST_FAIL;
                    else if (decision == DEC_FREEZE)      state_d = ST_DONE;
                    else if (iter_next == 4'(MAX_ITER))   state_d = ST_FAIL;
                    else                                  state_d = ST_SETTLE;
                end
                ST_DONE, ST_FAIL: if (start_ok) state_d = ST_SETTLE;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    // Datapath: window timing, edge counting, start latching and decision commit
    always_comb begin
        cyc_d      = '0;
        edge_cnt_d = edge_cnt_q;
        target_d   = target_q;
        tol_d      = tol_q;
        iter_d     = iter_q;
        meas_d     = meas_q;
        comp_d     = comp_q;

        if (((state_q == ST_SETTLE) || (state_q == ST_MEASURE)) && (state_d == state_q))
            cyc_d = cyc_q + CYC_W'(1);

        if (state_q == ST_SETTLE)
            edge_cnt_d = '0;
        else if ((state_q == ST_MEASURE) && rise && (edge_cnt_q != CNT_MAX))
            edge_cnt_d = edge_cnt_q + CNT_W'(1);

        if (start_ok && !abort_i) begin
            target_d = target_cnt_i;
            tol_d    = tol_i;
            iter_d   = '0;
        end

        if (commit) begin
            meas_d = dead ? '0 : edge_cnt_q;
            if (!dead) begin
                comp_d = decision;
                iter_d = iter_next;
            end
        end
    end

    // Decision results are visible during DECIDE itself so abort can still suppress them
    always_comb begin
        busy_o       = (state_q == ST_SETTLE) || (state_q == ST_MEASURE) || (state_q == ST_DECIDE);
        cal_done_o   = (state_q == ST_DONE);
        cal_fail_o   = (state_q == ST_FAIL);
        comp_valid_o = 1'b0;
        comp_out_o   = comp_q;
        meas_cnt_o   = meas_q;
        iter_cnt_o   = iter_q;
        if (commit) begin
            comp_valid_o = ~dead;
            comp_out_o   = comp_d;
            meas_cnt_o   = meas_d;
            iter_cnt_o   = iter_d;
        end
    end

endmodule

// File: tb/tb_afc_cal_sequencer.sv
// Directed self-checking bench for afc_cal_sequencer (default and wide-window instances).
// Honours AFC_SEQ_DEADVCO_EN for the held-low VCO expectations.
module tb_afc_cal_sequencer;

    logic       clk = 1'b0;
    logic       rstN;
    logic       start0, start1, abort;
    logic [9:0] targetCnt;
    logic [3:0] tol;
    logic       vcoDiv;
    int         vcoHalf = 0;
    int         checks = 0;
    int         errors = 0;

    logic [2:0] compOut0, compOut1;
    logic       compValid0, compValid1, busy0, busy1;
    logic       calDone0, calDone1, calFail0, calFail1;
    logic [9:0] measCnt0, measCnt1;
    logic [3:0] iterCnt0, iterCnt1;

    afc_cal_sequencer #(.CNT_W(10), .WIN_CYCLES(256), .SETTLE_CYCLES(32), .MAX_ITER(7)) dut0 (
        .clk_i(clk), .rst_ni(rstN), .start_i(start0), .abort_i(abort),
        .target_cnt_i(targetCnt), .tol_i(tol), .vco_div_i(vcoDiv),
        .comp_out_o(compOut0), .comp_valid_o(compValid0), .busy_o(busy0),
        .cal_done_o(calDone0), .cal_fail_o(calFail0), .meas_cnt_o(measCnt0), .iter_cnt_o(iterCnt0)
    );

    afc_cal_sequencer #(.CNT_W(10), .WIN_CYCLES(2100), .SETTLE_CYCLES(4), .MAX_ITER(7)) dut1 (
        .clk_i(clk), .rst_ni(rstN), .start_i(start1), .abort_i(abort),
        .target_cnt_i(targetCnt), .tol_i(tol), .vco_div_i(vcoDiv),
        .comp_out_o(compOut1), .comp_valid_o(compValid1), .busy_o(busy1),
        .cal_done_o(calDone1), .cal_fail_o(calFail1), .meas_cnt_o(measCnt1), .iter_cnt_o(iterCnt1)
    );

    always #5 clk = ~clk;

    // Divided VCO: toggles every vcoHalf clocks, held low when vcoHalf is 0
    initial begin
        int ph;
        ph = 0;
        vcoDiv = 1'b0;
        forever begin
            @(negedge clk);
            if (vcoHalf == 0) begin
                vcoDiv = 1'b0;
                ph = 0;
            end else begin
                ph++;
                if (ph >= vcoHalf) begin
                    vcoDiv = ~vcoDiv;
                    ph = 0;
                end
            end
        end
    end

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    // Issues a one-cycle start; returns #1 after the edge that samples it
    task automatic applyStimulus(input int which, input logic [9:0] tgt, input logic [3:0] tl);
        @(negedge clk);
        targetCnt = tgt;
        tol = tl;
        if (which == 0) start0 = 1'b1;
        else start1 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic waitValid(input int which, input int bound, output int n);
        bit found;
        found = 0;
        n = 0;
        while (!found && n < bound) begin
            @(posedge clk);
            #1;
            n++;
            if ((which == 0) ? compValid0 : compValid1) found = 1;
        end
        if (!found) n = -1;
    endtask

    task automatic countValid(input int which, input int edges, output int cnt);
        cnt = 0;
        for (int i = 0; i < edges; i++) begin
            @(posedge clk);
            #1;
            if ((which == 0) ? compValid0 : compValid1) cnt++;
        end
    endtask

    task automatic pulseAbort();
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
    endtask

    task automatic stepEdge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n, cnt;
        rstN = 1'b0; start0 = 1'b0; start1 = 1'b0; abort = 1'b0;
        targetCnt = '0; tol = '0; vcoHalf = 1;
        #23;
        checkOutput("rstCompOut", compOut0, 0);
        checkOutput("rstValid", compValid0, 0);
        checkOutput("rstBusy", busy0, 0);
        checkOutput("rstDone", calDone0, 0);
        checkOutput("rstFail", calFail0, 0);
        checkOutput("rstMeas", measCnt0, 0);
        checkOutput("rstIter", iterCnt0, 0);
        @(negedge clk);
        rstN = 1'b1;
        repeat (5) stepEdge();

        // In-tolerance count gives a single FREEZE and DONE
        applyStimulus(0, 10'd128, 4'd2);
        checkOutput("busyAfterStart", busy0, 1);
        waitValid(0, 400, n);
        checkOutput("freezeLatency", n, 288);
        checkOutput("freezeComp", compOut0, 1);
        checkOutput("freezeIter", iterCnt0, 1);
        checkOutput("freezeMeas", measCnt0, 128);
        checkOutput("doneDuringStrobe", calDone0, 0);
        stepEdge();
        checkOutput("strobeOneCycle", compValid0, 0);
        checkOutput("doneAfter", calDone0, 1);
        checkOutput("idleBusy", busy0, 0);

        // FAST then SLOW after the VCO slows down
        applyStimulus(0, 10'd100, 4'd2);
        waitValid(0, 400, n);
        checkOutput("fastLatency", n, 288);
        checkOutput("fastComp", compOut0, 2);
        checkOutput("fastMeas", measCnt0, 128);
        vcoHalf = 2;
        waitValid(0, 400, n);
        checkOutput("slowSpacing", n, 289);
        checkOutput("slowComp", compOut0, 4);
        checkOutput("slowMeas", measCnt0, 64);
        checkOutput("slowIter", iterCnt0, 2);
        stepEdge();
        checkOutput("settleBusy", busy0, 1);
        pulseAbort();
        checkOutput("abortSettleBusy", busy0, 0);
        checkOutput("abortHoldComp", compOut0, 4);

        // Seven SLOW decisions exhaust the iteration budget
        applyStimulus(0, 10'd128, 4'd2);
        for (int i = 1; i <= 7; i++) begin
            waitValid(0, 400, n);
            checkOutput("iterLatency", n, (i == 1) ? 288 : 289);
            checkOutput("iterComp", compOut0, 4);
            checkOutput("iterCount", iterCnt0, i);
        end
        stepEdge();
        checkOutput("failFlag", calFail0, 1);
        checkOutput("failBusy", busy0, 0);
        checkOutput("failDone", calDone0, 0);

        vcoHalf = 1;
        applyStimulus(0, 10'd128, 4'd2);
        checkOutput("restartIter", iterCnt0, 0);
        checkOutput("restartFail", calFail0, 0);
        waitValid(0, 400, n);
        checkOutput("restartLatency", n, 288);
        checkOutput("restartComp", compOut0, 1);
        checkOutput("restartIter1", iterCnt0, 1);
        stepEdge();

        // Abort during MEASURE
        vcoHalf = 2;
        applyStimulus(0, 10'd128, 4'd2);
        repeat (100) stepEdge();
        checkOutput("measureBusy", busy0, 1);
        pulseAbort();
        checkOutput("abortMeasBusy", busy0, 0);
        countValid(0, 400, cnt);
        checkOutput("abortMeasStrobes", cnt, 0);
        checkOutput("abortMeasMeas", measCnt0, 128);

        // Abort during DECIDE suppresses the strobe and the meas_cnt update
        applyStimulus(0, 10'd128, 4'd2);
        repeat (288) stepEdge();
        abort = 1'b1;
        #1;
        checkOutput("abortDecValid", compValid0, 0);
        checkOutput("abortDecMeas", measCnt0, 128);
        checkOutput("abortDecComp", compOut0, 1);
        @(posedge clk);
        #1;
        abort = 1'b0;
        checkOutput("abortDecBusy", busy0, 0);
        checkOutput("abortDecDone", calDone0, 0);
        checkOutput("abortDecIter", iterCnt0, 0);
        checkOutput("abortDecMeasAfter", measCnt0, 128);

        // Start while busy is ignored
        applyStimulus(0, 10'd128, 4'd2);
        repeat (50) stepEdge();
        start0 = 1'b1;
        stepEdge();
        start0 = 1'b0;
        waitValid(0, 400, n);
        checkOutput("busyStartLatency", n, 237);
        checkOutput("busyStartComp", compOut0, 4);
        checkOutput("busyStartIter", iterCnt0, 1);
        stepEdge();
        pulseAbort();

        // VCO held low
        vcoHalf = 0;
        repeat (10) stepEdge();
        applyStimulus(0, 10'd128, 4'd2);
`ifdef AFC_SEQ_DEADVCO_EN
        countValid(0, 289, cnt);
        checkOutput("deadStrobes", cnt, 0);
        checkOutput("deadFail", calFail0, 1);
        checkOutput("deadMeas", measCnt0, 0);
        checkOutput("deadIter", iterCnt0, 0);
`else
        waitValid(0, 400, n);
        checkOutput("zeroLatency", n, 288);
        checkOutput("zeroComp", compOut0, 4);
        checkOutput("zeroMeas", measCnt0, 0);
        stepEdge();
        pulseAbort();
        applyStimulus(0, 10'd5, 4'd15);
        waitValid(0, 400, n);
        checkOutput("loClampLatency", n, 288);
        checkOutput("loClampComp", compOut0, 1);
        stepEdge();
`endif

        // Asynchronous reset in SETTLE
        vcoHalf = 1;
        applyStimulus(0, 10'd128, 4'd2);
        repeat (10) stepEdge();
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("midRstBusy", busy0, 0);
        checkOutput("midRstComp", compOut0, 0);
        checkOutput("midRstValid", compValid0, 0);
        checkOutput("midRstMeas", measCnt0, 0);
        checkOutput("midRstIter", iterCnt0, 0);
        checkOutput("midRstDone", calDone0, 0);
        checkOutput("midRstFail", calFail0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstN = 1'b1;
        countValid(0, 300, cnt);
        checkOutput("midRstStrobes", cnt, 0);
        checkOutput("midRstIdle", busy0, 0);

        // Wide window: count saturation and hi-limit saturation
        applyStimulus(1, 10'd1020, 4'd15);
        waitValid(1, 2200, n);
        checkOutput("satLatency", n, 2104);
        checkOutput("satMeas", measCnt1, 1023);
        checkOutput("satComp", compOut1, 1);
        stepEdge();
        applyStimulus(1, 10'd1000, 4'd0);
        waitValid(1, 2200, n);
        checkOutput("satFastLatency", n, 2104);
        checkOutput("satFastComp", compOut1, 2);
        checkOutput("satFastMeas", measCnt1, 1023);
        stepEdge();
        pulseAbort();
        vcoHalf = 2;
        repeat (10) stepEdge();
        applyStimulus(1, 10'd1020, 4'd15);
        waitValid(1, 2200, n);
        checkOutput("wideSlowComp", compOut1, 4);
        checkOutput("wideSlowMeas", measCnt1, 525);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
